// File: rtl/stream_median5_filter.sv
// Streaming 5-tap median filter, valid/ready in and out, two-stage pipeline.
// Define BORDER_REPLICATE_EN to seed the whole window with the first sample.
module stream_median5_filter #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    function automatic logic [DW-1:0] min2(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] max2(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b
    );
        return (a < b) ? b : a;
    endfunction

    logic [DW-1:0] w_q [5];
    logic [DW-1:0] w_d [5];
    logic [2:0]    fill_q, fill_d;
    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_a_q, s1_b_q, s1_c_q;
    logic [DW-1:0] s1_a_d, s1_b_d, s1_c_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          en, accept, replicate, s1_load;
    logic [DW-1:0] lo01, hi01, lo23, hi23, med;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = !clear && en;
    assign accept   = in_valid && in_ready;

`ifdef BORDER_REPLICATE_EN
    assign replicate = (fill_q == 3'd0);
`else
    assign replicate = 1'b0;
`endif

    always_comb begin
        for (int i = 0; i < 5; i++) w_d[i] = w_q[i];
        fill_d = fill_q;
        if (accept) begin
            if (replicate) begin
                for (int i = 0; i < 5; i++) w_d[i] = in_data;
                fill_d = 3'd5;
            end else begin
                for (int i = 4; i > 0; i--) w_d[i] = w_q[i-1];
                w_d[0] = in_data;
                fill_d = (fill_q == 3'd5) ? 3'd5 : fill_q + 3'd1;
            end
        end
        if (clear) fill_d = 3'd0;
    end

    // Median of 5 = median of {max of pair mins, min of pair maxes, w4}
    assign lo01   = min2(w_d[0], w_d[1]);
    assign hi01   = max2(w_d[0], w_d[1]);
    assign lo23   = min2(w_d[2], w_d[3]);
    assign hi23   = max2(w_d[2], w_d[3]);
    assign s1_a_d = max2(lo01, lo23);
    assign s1_b_d = min2(hi01, hi23);
    assign s1_c_d = w_d[4];
    assign s1_load = accept && (fill_d == 3'd5);

    assign med = max2(min2(s1_a_q, s1_b_q),
                      min2(max2(s1_a_q, s1_b_q), s1_c_q));

    always_comb begin
        s1_valid_d  = s1_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (clear) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end else if (en) begin
            s1_valid_d  = s1_load;
            out_valid_d = s1_valid_q;
            if (s1_valid_q) out_data_d = med;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) w_q[i] <= '0;
            fill_q      <= 3'd0;
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_c_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            for (int i = 0; i < 5; i++) w_q[i] <= w_d[i];
            fill_q      <= fill_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            if (s1_load) begin
                s1_a_q <= s1_a_d;
                s1_b_q <= s1_b_d;
                s1_c_q <= s1_c_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_stream_median5_filter.sv
// Bench for stream_median5_filter: directed cases plus random traffic
// against a sort-based window model, checked through an output scoreboard.
module tb_stream_median5_filter;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] expq[$];
    logic [DW-1:0] win[$];
    logic [DW-1:0] seen[$];
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    stream_median5_filter #(.DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic logic [31:0] at(input int i);
        return (i >= 0 && i < seen.size()) ? 32'(seen[i]) : 32'hDEAD;
    endfunction

    // Window model: newest first, median = element 2 of the sorted copy
    function automatic void model_accept(input logic [DW-1:0] d);
        logic [DW-1:0] s[$];
`ifdef BORDER_REPLICATE_EN
        if (win.size() == 0) repeat (4) win.push_front(d);
`endif
        win.push_front(d);
        if (win.size() > 5) void'(win.pop_back());
        if (win.size() == 5) begin
            s = win;
            s.sort();
            expq.push_back(s[2]);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            win.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
            end
            chk("in_ready", 32'(in_ready),
                32'(!clear && (!out_valid || out_ready)));
            if (out_valid && out_ready) begin
                seen.push_back(out_data);
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out got=%0d exp=none",
                             out_data);
                end else begin
                    chk("median", 32'(out_data), 32'(expq.pop_front()));
                end
            end
            if (clear) begin
                expq.delete();
                win.delete();
            end else if (in_valid && in_ready) begin
                model_accept(in_data);
            end
            prev_stall = out_valid && !out_ready && !clear;
            prev_data  = out_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=stalled exp=accept");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (4) tick();
    endtask

    logic [19:0]   pats [4];
    logic [DW-1:0] pexp [4];

    initial begin
        int base;
        int n;
        pats = '{20'hFFFFF, 20'h00000, 20'h0F0F0, 20'hF0F0F};
        pexp = '{4'hF, 4'h0, 4'h0, 4'hF};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        tick();

`ifndef BORDER_REPLICATE_EN
        out_ready = 1'b1;
        base = seen.size();
        send(3); send(9); send(1); send(7);
        chk("t1_no_early", 32'(seen.size() - base), 0);
        send(5);
        chk("t1_lat_t1", 32'(out_valid), 0);
        tick();
        chk("t1_lat_valid", 32'(out_valid), 1);
        chk("t1_lat_data", 32'(out_data), 5);
        send(2); send(15); send(12);
        drain();
        chk("t1_count", 32'(seen.size() - base), 4);
        chk("t1_o0", at(base), 5);
        chk("t1_o1", at(base + 1), 5);
        chk("t1_o2", at(base + 2), 5);
        chk("t1_o3", at(base + 3), 7);
`endif

        do_clear();
        out_ready = 1'b1;
        send(7); send(5); send(2); send(15); send(12);
        drain();
        base = seen.size();
        out_ready = 1'b0;
        send(3);
        tick();
        tick();
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_data", 32'(out_data), 5);
        in_valid = 1'b1;
        in_data  = 4'd8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_in_ready", 32'(in_ready), 0);
            chk("t2_hold", 32'(out_data), 5);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8);
        drain();
        chk("t2_count", 32'(seen.size() - base), 2);
        chk("t2_o0", at(base), 5);
        chk("t2_o1", at(base + 1), 8);

`ifndef BORDER_REPLICATE_EN
        do_clear();
        drain();
        base = seen.size();
        send(4); send(4); send(4);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd9;
        @(negedge clk);
        chk("t3_clr_ready", 32'(in_ready), 0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        send(1); send(2); send(3); send(4);
        repeat (3) tick();
        chk("t3_no_out", 32'(seen.size() - base), 0);
        send(0);
        drain();
        chk("t3_count", 32'(seen.size() - base), 1);
        chk("t3_o0", at(base), 2);
`endif

        for (int k = 0; k < 4; k++) begin
            do_clear();
            base = seen.size();
            for (int j = 0; j < 5; j++) send(pats[k][4*j +: 4]);
            drain();
            chk("t4_some", 32'(seen.size() > base), 1);
            chk("t4_last", at(seen.size() - 1), 32'(pexp[k]));
        end

`ifndef BORDER_REPLICATE_EN
        do_clear();
        out_ready = 1'b0;
        send(1); send(2); send(3); send(4); send(5);
        n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        chk("t5_valid_before", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 0);
        chk("t5_rst_data", 32'(out_data), 0);
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        base = seen.size();
        send(6); send(7); send(8); send(9);
        repeat (3) tick();
        chk("t5_no_out", 32'(seen.size() - base), 0);
        send(10);
        drain();
        chk("t5_count", 32'(seen.size() - base), 1);
        chk("t5_o0", at(base), 8);
`else
        do_clear();
        drain();
        base = seen.size();
        send(6);
        chk("t6_lat_t1", 32'(out_valid), 0);
        tick();
        chk("t6_lat_valid", 32'(out_valid), 1);
        chk("t6_lat_data", 32'(out_data), 6);
        send(1); send(1); send(1);
        drain();
        chk("t6_count", 32'(seen.size() - base), 4);
        chk("t6_o0", at(base), 6);
        chk("t6_o1", at(base + 1), 6);
        chk("t6_o2", at(base + 2), 6);
        chk("t6_o3", at(base + 3), 1);
`endif

        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            clear     = ($urandom_range(0, 49) == 0);
            tick();
        end
        clear    = 1'b0;
        in_valid = 1'b0;
        drain();
        chk("final_queue_empty", 32'(expq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
